// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the IFU fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  // Fetch FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } ifu_state_e;

  // Architectural PC after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Instruction word presented when no real fetch data exists
  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_ctrl
// Description : IFU front end. Holds the PC, issues one instruction fetch at a
//               time, buffers the returned word and hands it to decode.
//               Flushes redirect the PC and discard any in-flight fetch.
//               Optional misaligned-fetch check: define IFU_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] pc_out,
  input  logic [31:0] npc_in,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        instr_adel
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

`ifdef IFU_ALIGN_CHECK_EN
  logic adel_q, adel_d;
  logic misaligned;

  // Fetch address is not word aligned: suppress the memory request
  assign misaligned = (pc_q[1:0] != 2'b00);
`endif

  // The PC register drives every address-like output directly
  assign pc_out        = pc_q;
  assign imem_req_addr = pc_q;
  assign instr_pc      = pc_q;
  assign instr         = instr_q;

  // Decode never sees a valid instruction in a flush cycle
  assign instr_valid = (state_q == S_HOLD) && !flush_valid;

  // Request is raised in REQ regardless of flush
`ifdef IFU_ALIGN_CHECK_EN
  assign imem_req_valid = (state_q == S_REQ) && !misaligned;
  assign instr_adel     = adel_q;
`else
  assign imem_req_valid = (state_q == S_REQ);
`endif

  // State, PC and instruction buffer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
`ifdef IFU_ALIGN_CHECK_EN
      adel_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef IFU_ALIGN_CHECK_EN
      adel_q  <= adel_d;
`endif
    end
  end

  // Next-state logic; flush overrides every other event in its cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef IFU_ALIGN_CHECK_EN
    adel_d  = adel_q;
`endif

    unique case (state_q)
      S_REQ: begin
        if (flush_valid) begin
          pc_d = flush_pc;
          // An accepted request still owes a response, which must be drained
          if (imem_req_valid && imem_req_ready) state_d = S_DRAIN;
          else                                  state_d = S_REQ;
        end
`ifdef IFU_ALIGN_CHECK_EN
        else if (misaligned) begin
          state_d = S_HOLD;
          instr_d = NOP;
          adel_d  = 1'b1;
        end
`endif
        else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush_valid) begin
          pc_d = flush_pc;
          // A response arriving with the flush closes the transaction
          state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (flush_valid) begin
          pc_d    = flush_pc;
          state_d = S_REQ;
`ifdef IFU_ALIGN_CHECK_EN
          adel_d  = 1'b0;
`endif
        end else if (instr_ready) begin
          pc_d    = npc_in;
          state_d = S_REQ;
`ifdef IFU_ALIGN_CHECK_EN
          adel_d  = 1'b0;
`endif
        end
      end

      S_DRAIN: begin
        if (flush_valid) begin
          pc_d = flush_pc;
          // The owed response arriving now settles the transaction; waiting
          // for another one would never complete
          state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

endmodule : ifu_fetch_ctrl
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch_ctrl
// Description : Directed, table-driven self-checking bench for ifu_fetch_ctrl.
//               Optional misaligned-fetch sequence under IFU_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_out;
  logic [31:0] npc_in;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef IFU_ALIGN_CHECK_EN
  logic        instr_adel;
`endif

  int checks = 0;
  int errors = 0;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_out         (pc_out),
    .npc_in         (npc_in),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .instr_adel     (instr_adel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected before the next edge
  typedef struct packed {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        fv;
    logic [31:0] fp;
    logic [31:0] npc;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rr, input logic rv, input logic [31:0] rd,
                     input logic ir, input logic fv, input logic [31:0] fp,
                     input logic [31:0] npc, input logic e_rqv,
                     input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_instr);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.fv = fv; v.fp = fp;
    v.npc = npc; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_instr = e_instr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic fv, input logic [31:0] fp,
                       input logic [31:0] npc);
    imem_req_ready = rr; imem_rsp_valid = rv; imem_rsp_data = rd;
    instr_ready = ir; flush_valid = fv; flush_pc = fp; npc_in = npc;
  endtask

  task automatic chk_outs(input string tag, input logic e_rqv,
                          input logic [31:0] e_addr, input logic e_iv,
                          input logic [31:0] e_instr);
    chk({tag, " req_valid"},   {31'd0, imem_req_valid}, {31'd0, e_rqv});
    chk({tag, " req_addr"},    imem_req_addr, e_addr);
    chk({tag, " pc_out"},      pc_out, e_addr);
    chk({tag, " instr_pc"},    instr_pc, e_addr);
    chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, e_iv});
    chk({tag, " instr"},       instr, e_instr);
  endtask

  initial begin
    // ------------------------------------------------------------ table
    //   rr rv rd            ir fv fp            npc           rqv addr          iv instr
    // Sequential fetch, 3-cycle spacing
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h3000, 0, 32'h0);
    add(0, 1, 32'hAAAA0001, 0, 0, 32'h0,        32'h0,        0, 32'h3000, 0, 32'h0);
    add(0, 0, 32'h0,        1, 0, 32'h0,        32'h3004,     0, 32'h3000, 1, 32'hAAAA0001);
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h3004, 0, 32'hAAAA0001);
    add(0, 1, 32'hAAAA0002, 0, 0, 32'h0,        32'h0,        0, 32'h3004, 0, 32'hAAAA0001);
    add(0, 0, 32'h0,        1, 0, 32'h0,        32'h3008,     0, 32'h3004, 1, 32'hAAAA0002);
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h3008, 0, 32'hAAAA0002);
    add(0, 1, 32'hAAAA0003, 0, 0, 32'h0,        32'h0,        0, 32'h3008, 0, 32'hAAAA0002);
    add(0, 0, 32'h0,        1, 0, 32'h0,        32'h300C,     0, 32'h3008, 1, 32'hAAAA0003);
    // Backpressure: memory not ready for 4 cycles
    for (int i = 0; i < 4; i++)
      add(0, 0, 32'h0,      0, 0, 32'h0,        32'h0,        1, 32'h300C, 0, 32'hAAAA0003);
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h300C, 0, 32'hAAAA0003);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h300C, 0, 32'hAAAA0003);
    add(0, 1, 32'hBBBB0004, 0, 0, 32'h0,        32'h0,        0, 32'h300C, 0, 32'hAAAA0003);
    // Backpressure: decode not ready for 5 cycles
    for (int i = 0; i < 5; i++)
      add(0, 0, 32'h0,      0, 0, 32'h0,        32'h3010,     0, 32'h300C, 1, 32'hBBBB0004);
    add(0, 0, 32'h0,        1, 0, 32'h0,        32'h3010,     0, 32'h300C, 1, 32'hBBBB0004);
    // Flush in WAIT without response -> DRAIN swallows 0xDEADBEEF
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h3010, 0, 32'hBBBB0004);
    add(0, 0, 32'h0,        0, 1, 32'h4180,     32'h0,        0, 32'h3010, 0, 32'hBBBB0004);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h4180, 0, 32'hBBBB0004);
    add(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        0, 32'h4180, 0, 32'hBBBB0004);
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h4180, 0, 32'hBBBB0004);
    add(0, 1, 32'hCCCC0005, 0, 0, 32'h0,        32'h0,        0, 32'h4180, 0, 32'hBBBB0004);
    // Flush in HOLD together with instr_ready: npc_in ignored
    add(0, 0, 32'h0,        1, 1, 32'h5000,     32'h4184,     0, 32'h4180, 0, 32'hCCCC0005);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h5000, 0, 32'hCCCC0005);
    // Flush coinciding with request acceptance -> DRAIN
    add(1, 0, 32'h0,        0, 1, 32'h6000,     32'h0,        1, 32'h5000, 0, 32'hCCCC0005);
    add(0, 1, 32'h11111111, 0, 0, 32'h0,        32'h0,        0, 32'h6000, 0, 32'hCCCC0005);
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h6000, 0, 32'hCCCC0005);
    add(0, 1, 32'hCCCC0006, 0, 0, 32'h0,        32'h0,        0, 32'h6000, 0, 32'hCCCC0005);
    add(0, 0, 32'h0,        1, 0, 32'h0,        32'h6004,     0, 32'h6000, 1, 32'hCCCC0006);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h6004, 0, 32'hCCCC0006);
    // Flush in REQ without ready: stays in REQ at new PC
    add(0, 0, 32'h0,        0, 1, 32'h7000,     32'h0,        1, 32'h6004, 0, 32'hCCCC0006);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h7000, 0, 32'hCCCC0006);
    // Flush in WAIT with response: word discarded, back to REQ
    add(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h7000, 0, 32'hCCCC0006);
    add(0, 1, 32'h99999999, 0, 1, 32'h7100,     32'h0,        0, 32'h7000, 0, 32'hCCCC0006);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h7100, 0, 32'hCCCC0006);
    // Stray response in REQ is ignored
    add(0, 1, 32'h55555555, 0, 0, 32'h0,        32'h0,        1, 32'h7100, 0, 32'hCCCC0006);
    add(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h7100, 0, 32'hCCCC0006);

    // ------------------------------------------------------------ reset
    reset_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset pc_out",      pc_out, 32'h3000);
    chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset instr",       instr, 32'h0);
`ifdef IFU_ALIGN_CHECK_EN
    chk("reset instr_adel",  {31'd0, instr_adel}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // ------------------------------------------------------------ vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].ir, vecs[i].fv,
            vecs[i].fp, vecs[i].npc);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_rqv, vecs[i].e_addr,
               vecs[i].e_iv, vecs[i].e_instr);
    end

`ifdef IFU_ALIGN_CHECK_EN
    // ------------------------------------------------------------ misaligned
    // Fetch at 0x7100, decode supplies a misaligned next PC 0x3006
    @(negedge clk); drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); drive(0, 1, 32'h12345678, 0, 0, 32'h0, 32'h0);
    @(negedge clk); drive(0, 0, 32'h0, 1, 0, 32'h0, 32'h3006);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    chk_outs("adel req", 1'b0, 32'h3006, 1'b0, 32'h12345678);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    chk_outs("adel hold", 1'b0, 32'h3006, 1'b1, 32'h0);
    chk("adel flag", {31'd0, instr_adel}, 32'd1);
    @(negedge clk); drive(0, 0, 32'h0, 1, 0, 32'h0, 32'h3008);
    #1;
    chk("adel flag held", {31'd0, instr_adel}, 32'd1);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("adel cleared", {31'd0, instr_adel}, 32'd0);
    chk_outs("adel next", 1'b1, 32'h3008, 1'b0, 32'h0);
`endif

    // ------------------------------------------------------------ reset mid-fetch
    @(negedge clk); drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("midreset pc_out",      pc_out, 32'h3000);
    chk("midreset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("midreset req_valid",   {31'd0, imem_req_valid}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(0, 1, 32'hEEEE0000, 0, 0, 32'h0, 32'h0);
    #1;
    chk_outs("after reset", 1'b1, 32'h3000, 1'b0, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    #1;
    chk_outs("stray rsp after reset", 1'b1, 32'h3000, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ifu_fetch_ctrl
`default_nettype wire
